bp_pma_arbiter: RTL and testbench
=================================

# bp_pma_arbiter

Shares one physical-memory-attribute (PMA) classifier between `num_req_p` requesters, typically I-side and D-side tag paths, with round-robin arbitration. Each requester gets a one-entry registered response slot. The block also owns the uncached and nonspec mode registers. Mode updates arrive on a config handshake and are applied only after all in-flight lookups have drained, so every response is classified under exactly one mode setting.

## Interface
- `bp_params_p`, default `e_bp_default_cfg`: processor config; supplies `ptag_width_p`, `hio_width_p`, `dram_base_addr_gp`, `page_offset_width_gp`.
- `num_req_p`, default 2: number of requesters, ≥ 2.

Ports:
- `clk_i`  in  1  sole clock.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `cfg_v_i`  in  1  mode update valid.
- `cfg_uncached_mode_i`  in  1  new uncached mode.
- `cfg_nonspec_mode_i`  in  1  new nonspec mode.
- `cfg_ready_o`  out  1  update accepted when `cfg_v_i & cfg_ready_o`.
- `uncached_mode_o`, `nonspec_mode_o`  out  1 each  current mode registers.
- `req_v_i`  in  `num_req_p`  per-requester lookup valid.
- `req_ptag_i`  in  `num_req_p*ptag_width_p`  per-requester ptag.
- `req_ready_o`  out  `num_req_p`  request accepted when `v & ready`.
- `resp_v_o`  out  `num_req_p`  response slot full.
- `resp_uncached_o`, `resp_nonidem_o`  out  `num_req_p` each  per-slot result.
- `resp_yumi_i`  in  `num_req_p`  consumer pops slot; legal only when `resp_v_o` is high.

## Operation
- Classification of ptag `p`:
  - `local = p < (dram_base_addr_gp >> page_offset_width_gp)`.
  - `io = p[ptag_width_p-1 -: hio_width_p] != 0`.
  - `uncached = local | io | uncached_mode`.
  - `nonidem = io | uncached_mode | nonspec_mode`.
- Control FSM, `e_run`/`e_drain`/`e_update`, reset to `e_run`:
  - `e_run`: grants allowed. `cfg_ready_o = 1`. On cfg accept, latch pending values and go to `e_drain`.
  - `e_drain`: no grants, `cfg_ready_o = 0`. When all slots are empty (after this cycle's yumis), go to `e_update`.
  - `e_update`: write pending values into the mode registers, no grants, `cfg_ready_o = 0`, then go to `e_run`.
- Arbitration, `e_run` only:
  - Eligible requester `i`: `req_v_i[i] & (slot i empty | resp_yumi_i[i])`.
  - Exactly one eligible requester is granted per cycle. Round-robin search starts at `rr_ptr`.
  - `req_ready_o[i] = 1` only for the granted `i`.
  - `rr_ptr` becomes grant+1 (mod `num_req_p`) on accept. It is unchanged when nothing is accepted.
- Slot `i`:
  - Accept writes the classification of the granted ptag, using the current mode registers, and sets full.
  - Yumi without accept clears full.
  - Yumi and accept in the same cycle keeps the slot full with the new data.
- A cfg accept in the same cycle as a request accept is legal. The request is classified with the old mode.

## Timing
- Reset values: all `resp_v_o = 0`, slot data = 0, mode registers = 0, `rr_ptr = 0`, FSM = `e_run`.
- `cfg_ready_o = 1` after reset; `req_ready_o = 0` until a valid request appears.
- Lookup latency: accept in cycle N gives `resp_v_o` high in cycle N+1.
- Throughput: one lookup per cycle aggregate; one per cycle per requester when its consumer yumis every cycle.
- `req_ready_o` depends combinationally on `req_v_i`, `resp_yumi_i` and state. `req_ready_o` never feeds `req_v_i`.
- Mode change latency: cfg accept in cycle N with all slots empty gives `e_drain` in N+1, `e_update` in N+2, and new modes visible on `*_mode_o` in N+3. The first grant under the new mode is in N+3.
- Reset asserted mid-operation: all slots clear immediately (asynchronous). Pending cfg is discarded.

## Structure
- Shared package `bp_common_pkg` gets:
  - the enum `bp_pma_arb_state_e`;
  - the struct `bp_pma_attr_s {uncached, nonidem}`.
- Sub-module `bp_pma`: combinational classifier, one instance, fed by the mux of the granted ptag and the mode registers.
- Round-robin: `bsg_arb_round_robin`, or an equivalent local priority encoder plus pointer.

## Test plan
Config for all cases: `dram_base 0x8000_0000`, page offset 12, local threshold ptag `0x80000`.
- Single request, ptag `0x80010`, modes 0 → `resp_v_o` next cycle, `uncached = 0`, `nonidem = 0`. Ptag `0x00100` → `uncached = 1`, `nonidem = 0`.
- IO ptag (top `hio` bits = 1), modes 0 → `uncached = 1`, `nonidem = 1`.
- Both requesters assert continuously with yumi every cycle → grants alternate 0, 1, 0, 1. No starvation. One accept per cycle.
- Requester 0 slot full with no yumi → `req_ready_o[0] = 0` and requester 1 is still served. Yumi and new request in the same cycle → slot reloads and `resp_v_o` stays high.
- Both slots full, cfg `{uncached = 0, nonspec = 1}` accepted → no grants until both slots are yumied. `nonspec_mode_o` rises 2 cycles after drain completes. Ptag `0x80010` then returns `uncached = 0`, `nonidem = 1`.
- Assert `reset_n_i` low mid-drain → `resp_v_o = 0` and modes = 0 asynchronously. FSM returns to `e_run` after release.

Source files
------------

// File: rtl/bp_common_pkg.sv
// Shared types for the PMA arbiter: processor config record, FSM states and
// the per-lookup attribute pair.
package bp_common_pkg;

   typedef enum logic [0:0] {
      e_bp_default_cfg
   } bp_params_e;

   typedef struct packed {
      int          ptag_width;
      int          hio_width;
      logic [63:0] dram_base_addr;
      int          page_offset_width;
   } bp_proc_param_s;

   localparam bp_proc_param_s bp_default_cfg_p = '{
      ptag_width:        28,
      hio_width:         4,
      dram_base_addr:    64'h0000_0000_8000_0000,
      page_offset_width: 12
   };

   function automatic bp_proc_param_s bp_get_cfg(bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return bp_default_cfg_p;
         default:          return bp_default_cfg_p;
      endcase
   endfunction

   typedef enum logic [1:0] {
      e_run,
      e_drain,
      e_update
   } bp_pma_arb_state_e;

   typedef struct packed {
      logic uncached;
      logic nonidem;
   } bp_pma_attr_s;

endpackage

// File: rtl/bp_pma.sv
// Combinational physical-memory-attribute classifier: local (below DRAM) and
// IO (nonzero high bits) regions, overridden by the global mode bits.
module bp_pma
   import bp_common_pkg::*;
#(
   parameter bp_params_e bp_params_p = e_bp_default_cfg,
   localparam bp_proc_param_s cfg_lp = bp_get_cfg(bp_params_p),
   localparam int ptag_width_p = cfg_lp.ptag_width,
   localparam int hio_width_p = cfg_lp.hio_width
)(
   input  logic [ptag_width_p-1:0] ptag_i,
   input  logic                    uncached_mode_i,
   input  logic                    nonspec_mode_i,
   output logic                    uncached_o,
   output logic                    nonidem_o
);

   localparam logic [63:0] local_limit_full_lp = cfg_lp.dram_base_addr >> cfg_lp.page_offset_width;
   localparam logic [ptag_width_p-1:0] local_limit_lp = local_limit_full_lp[ptag_width_p-1:0];

   logic         is_local;
   logic         is_io;
   bp_pma_attr_s attr;

   assign is_local = (ptag_i < local_limit_lp);
   assign is_io    = |ptag_i[ptag_width_p-1 -: hio_width_p];

   assign attr.uncached = is_local | is_io | uncached_mode_i;
   assign attr.nonidem  = is_io | uncached_mode_i | nonspec_mode_i;

   assign uncached_o = attr.uncached;
   assign nonidem_o  = attr.nonidem;

endmodule

// File: rtl/bp_pma_arbiter.sv
// Round-robin sharing of one PMA classifier among requesters, with one-entry
// response slots and drain-then-update handling of the mode registers.
module bp_pma_arbiter
   import bp_common_pkg::*;
#(
   parameter bp_params_e bp_params_p = e_bp_default_cfg,
   parameter int num_req_p = 2,
   localparam bp_proc_param_s cfg_lp = bp_get_cfg(bp_params_p),
   localparam int ptag_width_p = cfg_lp.ptag_width
)(
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic                              cfg_v_i,
   input  logic                              cfg_uncached_mode_i,
   input  logic                              cfg_nonspec_mode_i,
   output logic                              cfg_ready_o,
   output logic                              uncached_mode_o,
   output logic                              nonspec_mode_o,
   input  logic [num_req_p-1:0]              req_v_i,
   input  logic [num_req_p*ptag_width_p-1:0] req_ptag_i,
   output logic [num_req_p-1:0]              req_ready_o,
   output logic [num_req_p-1:0]              resp_v_o,
   output logic [num_req_p-1:0]              resp_uncached_o,
   output logic [num_req_p-1:0]              resp_nonidem_o,
   input  logic [num_req_p-1:0]              resp_yumi_i
);

   localparam int idx_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

   bp_pma_arb_state_e       state_r;
   logic [idx_w_lp-1:0]     rr_ptr_r;
   logic                    pend_uncached_r, pend_nonspec_r;
   logic                    uncached_mode_r, nonspec_mode_r;

   logic [num_req_p-1:0]    slot_v;
   logic [num_req_p-1:0]    eligible;
   logic [ptag_width_p-1:0] ptag_arr [num_req_p];
   logic [ptag_width_p-1:0] grant_ptag;
   logic [idx_w_lp-1:0]     grant_idx;
   logic                    grant_found;
   logic                    grant_v;
   logic                    cfg_accept;
   logic                    all_empty_next;
   bp_pma_attr_s            grant_attr;

   genvar gi;
   generate
      for (gi = 0; gi < num_req_p; gi++) begin : g_req
         assign ptag_arr[gi] = req_ptag_i[gi*ptag_width_p +: ptag_width_p];
         // A slot can take a new lookup in the same cycle its consumer pops it.
         assign eligible[gi] = req_v_i[gi] & (~slot_v[gi] | resp_yumi_i[gi]);
      end
   endgenerate

   always_comb begin
      logic [idx_w_lp-1:0] cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < num_req_p; k++) begin
         cand = idx_w_lp'((int'(rr_ptr_r) + k) % num_req_p);
         if (!grant_found && eligible[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign grant_v     = (state_r == e_run) & grant_found;
   assign req_ready_o = grant_v ? (num_req_p'(1) << grant_idx) : '0;
   assign grant_ptag  = ptag_arr[grant_idx];

   bp_pma #(
      .bp_params_p(bp_params_p)
   ) pma (
      .ptag_i         (grant_ptag),
      .uncached_mode_i(uncached_mode_r),
      .nonspec_mode_i (nonspec_mode_r),
      .uncached_o     (grant_attr.uncached),
      .nonidem_o      (grant_attr.nonidem)
   );

   generate
      for (gi = 0; gi < num_req_p; gi++) begin : g_slot
         logic         v_r;
         bp_pma_attr_s attr_r;
         logic         accept;

         assign accept = grant_v & (grant_idx == idx_w_lp'(gi));

         always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
               v_r    <= 1'b0;
               attr_r <= '0;
            end else if (accept) begin
               v_r    <= 1'b1;
               attr_r <= grant_attr;
            end else if (resp_yumi_i[gi]) begin
               v_r    <= 1'b0;
            end
         end

         assign slot_v[gi]          = v_r;
         assign resp_v_o[gi]        = v_r;
         assign resp_uncached_o[gi] = attr_r.uncached;
         assign resp_nonidem_o[gi]  = attr_r.nonidem;
      end
   endgenerate

   assign cfg_accept     = cfg_v_i & (state_r == e_run);
   assign all_empty_next = ~|(slot_v & ~resp_yumi_i);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r         <= e_run;
         rr_ptr_r        <= '0;
         pend_uncached_r <= 1'b0;
         pend_nonspec_r  <= 1'b0;
         uncached_mode_r <= 1'b0;
         nonspec_mode_r  <= 1'b0;
      end else begin
         if (grant_v)
            rr_ptr_r <= (grant_idx == idx_w_lp'(num_req_p-1)) ? '0 : grant_idx + 1'b1;
         case (state_r)
            e_run: begin
               if (cfg_accept) begin
                  pend_uncached_r <= cfg_uncached_mode_i;
                  pend_nonspec_r  <= cfg_nonspec_mode_i;
                  state_r         <= e_drain;
               end
            end
            e_drain: begin
               if (all_empty_next)
                  state_r <= e_update;
            end
            e_update: begin
               uncached_mode_r <= pend_uncached_r;
               nonspec_mode_r  <= pend_nonspec_r;
               state_r         <= e_run;
            end
            default: state_r <= e_run;
         endcase
      end
   end

   assign cfg_ready_o     = (state_r == e_run);
   assign uncached_mode_o = uncached_mode_r;
   assign nonspec_mode_o  = nonspec_mode_r;

endmodule

// File: tb/tb_bp_pma_arbiter.sv
// Directed bench for bp_pma_arbiter: classification, round-robin, slot
// backpressure, drained mode update and asynchronous reset.
module tb_bp_pma_arbiter;

   localparam int W = 28;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         cfg_v, cfg_unc, cfg_nsp;
   logic         cfg_ready, unc_mode, nsp_mode;
   logic [1:0]   req_v, req_ready, resp_v, resp_unc, resp_nid, yumi;
   logic [W-1:0] ptag0, ptag1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bp_pma_arbiter #(.num_req_p(2)) dut (
      .clk_i              (clk),
      .reset_n_i          (reset_n),
      .cfg_v_i            (cfg_v),
      .cfg_uncached_mode_i(cfg_unc),
      .cfg_nonspec_mode_i (cfg_nsp),
      .cfg_ready_o        (cfg_ready),
      .uncached_mode_o    (unc_mode),
      .nonspec_mode_o     (nsp_mode),
      .req_v_i            (req_v),
      .req_ptag_i         ({ptag1, ptag0}),
      .req_ready_o        (req_ready),
      .resp_v_o           (resp_v),
      .resp_uncached_o    (resp_unc),
      .resp_nonidem_o     (resp_nid),
      .resp_yumi_i        (yumi)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      logic [1:0] rr_exp [4];
      rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

      reset_n = 1'b0;
      cfg_v = 1'b0; cfg_unc = 1'b0; cfg_nsp = 1'b0;
      req_v = 2'b00; yumi = 2'b00; ptag0 = '0; ptag1 = '0;
      #23;
      check("rst_resp_v", resp_v, 2'b00);
      check("rst_unc_mode", unc_mode, 1'b0);
      check("rst_nsp_mode", nsp_mode, 1'b0);
      check("rst_cfg_ready", cfg_ready, 1'b1);
      check("rst_req_ready", req_ready, 2'b00);
      reset_n = 1'b1;
      cyc();

      // DRAM ptag, modes off
      req_v = 2'b01; ptag0 = 28'h0080010;
      settle(); check("dram_ready", req_ready, 2'b01);
      cyc(); req_v = 2'b00;
      check("dram_resp_v", resp_v, 2'b01);
      check("dram_unc", resp_unc[0], 1'b0);
      check("dram_nid", resp_nid[0], 1'b0);

      // local ptag reloads slot 0 in the cycle it is popped
      yumi = 2'b01; req_v = 2'b01; ptag0 = 28'h0000100;
      settle(); check("reload_ready", req_ready, 2'b01);
      cyc(); yumi = 2'b00; req_v = 2'b00;
      check("reload_resp_v", resp_v, 2'b01);
      check("local_unc", resp_unc[0], 1'b1);
      check("local_nid", resp_nid[0], 1'b0);
      yumi = 2'b01; cyc(); yumi = 2'b00;
      check("pop_resp_v", resp_v, 2'b00);

      // IO ptag on requester 1
      req_v = 2'b10; ptag1 = 28'h1000010;
      settle(); check("io_ready", req_ready, 2'b10);
      cyc(); req_v = 2'b00;
      check("io_resp_v", resp_v, 2'b10);
      check("io_unc", resp_unc[1], 1'b1);
      check("io_nid", resp_nid[1], 1'b1);
      yumi = 2'b10; cyc(); yumi = 2'b00;

      // both requesters streaming with consumers always popping
      ptag0 = 28'h0080010; ptag1 = 28'h0080010;
      for (int k = 0; k < 4; k++) begin
         req_v = 2'b11; yumi = resp_v;
         settle(); check($sformatf("rr_grant%0d", k), req_ready, rr_exp[k]);
         cyc();
      end
      req_v = 2'b00; yumi = resp_v; cyc(); yumi = 2'b00;
      check("rr_drained", resp_v, 2'b00);

      // slot 0 held full: requester 1 still served, then nobody
      req_v = 2'b01;
      settle(); check("blk_fill0", req_ready, 2'b01);
      cyc();
      req_v = 2'b11;
      settle(); check("blk_skip0", req_ready, 2'b10);
      cyc();
      settle(); check("blk_both_full", req_ready, 2'b00);

      // mode update waits for both slots to drain
      cfg_v = 1'b1; cfg_unc = 1'b0; cfg_nsp = 1'b1;
      settle(); check("cfg_ready_run", cfg_ready, 1'b1);
      cyc(); cfg_v = 1'b0;
      yumi = 2'b01;
      settle(); check("drain_no_grant0", req_ready, 2'b00);
      check("drain_cfg_ready", cfg_ready, 1'b0);
      cyc();
      yumi = 2'b10;
      settle(); check("drain_no_grant1", req_ready, 2'b00);
      check("drain_nsp_old", nsp_mode, 1'b0);
      cyc();
      yumi = 2'b00;
      settle(); check("update_no_grant", req_ready, 2'b00);
      check("update_nsp_old", nsp_mode, 1'b0);
      cyc();
      check("new_nsp_mode", nsp_mode, 1'b1);
      check("new_unc_mode", unc_mode, 1'b0);
      settle(); check("post_update_grant", req_ready, 2'b01);
      cyc(); req_v = 2'b00;
      check("nsp_resp_v", resp_v, 2'b01);
      check("nsp_unc", resp_unc[0], 1'b0);
      check("nsp_nid", resp_nid[0], 1'b1);

      // reset while draining with slot 0 still full
      cfg_v = 1'b1; cfg_unc = 1'b1; cfg_nsp = 1'b0;
      cyc(); cfg_v = 1'b0;
      settle(); check("mid_drain_cfg_ready", cfg_ready, 1'b0);
      reset_n = 1'b0;
      #1;
      check("async_resp_v", resp_v, 2'b00);
      check("async_nsp_mode", nsp_mode, 1'b0);
      check("async_cfg_ready", cfg_ready, 1'b1);
      cyc();
      reset_n = 1'b1;
      cyc();
      check("post_rst_unc_mode", unc_mode, 1'b0);
      req_v = 2'b01; ptag0 = 28'h0000100;
      settle(); check("post_rst_ready", req_ready, 2'b01);
      cyc(); req_v = 2'b00;
      check("post_rst_unc", resp_unc[0], 1'b1);
      check("post_rst_nid", resp_nid[0], 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
